// File: rtl/frame_pixel_streamer.sv
// frame_pixel_streamer: snapshots a flat WIDTH*HEIGHT*8-bit frame bus on
// start, then emits it one pixel per valid/ready beat in raster order.
// Ports:
//   clk, rst             rising-edge clock, synchronous active-high reset
//   frame_in, start      flat frame (pixel p = bits 8p..8p+7), capture request
//   busy, done           activity flag, one-cycle end-of-frame pulse
//   pix_data, pix_bin    pixel value and its nonzero flag
//   pix_valid, pix_ready beat handshake
//   pix_sof/eol/eof      first pixel, last column, last pixel
//   pix_row, pix_col     raster position of the presented beat
module frame_pixel_streamer #(
  parameter int WIDTH  = 10,
  parameter int HEIGHT = 10,
  parameter int CW     = (WIDTH  > 1) ? $clog2(WIDTH)  : 1,
  parameter int RW     = (HEIGHT > 1) ? $clog2(HEIGHT) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [0:WIDTH*HEIGHT*8-1] frame_in,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  output logic [7:0]                pix_data,
  output logic                      pix_bin,
  output logic                      pix_valid,
  input  logic                      pix_ready,
  output logic                      pix_sof,
  output logic                      pix_eol,
  output logic                      pix_eof,
  output logic [RW-1:0]             pix_row,
  output logic [CW-1:0]             pix_col
);

  localparam int NPIX = WIDTH * HEIGHT;
  localparam int FW   = NPIX * 8;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DONE
  } state_t;

  state_t        state_q, state_d;
  logic [0:FW-1] shadow_q, shadow_d;
  logic [RW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          valid_q, valid_d;
  logic [7:0]    data_q, data_d;
  logic          bin_q, bin_d;
  logic          sof_q, sof_d;
  logic          eol_q, eol_d;
  logic          eof_q, eof_d;
  logic          load;
  logic [7:0]    mux_data;

  // Counters always name the beat on the output flops; load refreshes
  // the output flops from the shadow at the next counter position.
  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    row_d    = row_q;
    col_d    = col_q;
    valid_d  = valid_q;
    done_d   = 1'b0;
    load     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          shadow_d = frame_in;
          row_d    = '0;
          col_d    = '0;
          state_d  = STREAM;
        end
      end
      STREAM: begin
        // First cycle after capture fills the output flops.
        if (!valid_q) begin
          valid_d = 1'b1;
          load    = 1'b1;
        end else if (pix_ready) begin
          if (eof_q) begin
            valid_d = 1'b0;
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            load = 1'b1;
            if (eol_q) begin
              col_d = '0;
              row_d = row_q + RW'(1);
            end else begin
              col_d = col_q + CW'(1);
            end
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_comb begin
    int idx;
    idx      = int'(row_d) * WIDTH + int'(col_d);
    mux_data = '0;
    for (int p = 0; p < NPIX; p++) begin
      if (p == idx) begin
        for (int k = 0; k < 8; k++) begin
          mux_data[k] = shadow_q[8*p+k];
        end
      end
    end
  end

  always_comb begin
    data_d = data_q;
    bin_d  = bin_q;
    sof_d  = sof_q;
    eol_d  = eol_q;
    eof_d  = eof_q;
    if (load) begin
      data_d = mux_data;
      bin_d  = |mux_data;
      sof_d  = (row_d == '0) && (col_d == '0);
      eol_d  = (col_d == CW'(WIDTH-1));
      eof_d  = (col_d == CW'(WIDTH-1)) &&
               (row_d == RW'(HEIGHT-1));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      row_q   <= '0;
      col_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
      bin_q   <= 1'b0;
      sof_q   <= 1'b0;
      eol_q   <= 1'b0;
      eof_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      bin_q   <= bin_d;
      sof_q   <= sof_d;
      eol_q   <= eol_d;
      eof_q   <= eof_d;
    end
  end

  // Shadow keeps its contents across reset.
  always_ff @(posedge clk) begin
    shadow_q <= shadow_d;
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign pix_data  = data_q;
  assign pix_bin   = bin_q;
  assign pix_valid = valid_q;
  assign pix_sof   = sof_q;
  assign pix_eol   = eol_q;
  assign pix_eof   = eof_q;
  assign pix_row   = row_q;
  assign pix_col   = col_q;

endmodule

// File: tb/tb_frame_pixel_streamer.sv
// tb_frame_pixel_streamer: scoreboard bench for 10x10, 1x1 and 3x1 builds.
// Expected beats come from a raster model pushed at start time.
module tb_frame_pixel_streamer;

  typedef struct {
    int data;
    int bin;
    int row;
    int col;
    int sof;
    int eol;
    int eof;
  } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic ready;

  logic [0:799] f10;
  logic         s10, busy10, done10, b10, v10;
  logic         sof10, eol10, eof10;
  logic [7:0]   d10;
  logic [3:0]   r10, c10;

  logic [0:7]   f11;
  logic         s11, busy11, done11, b11, v11;
  logic         sof11, eol11, eof11;
  logic [7:0]   d11;
  logic [0:0]   r11, c11;

  logic [0:23]  f31;
  logic         s31, busy31, done31, b31, v31;
  logic         sof31, eol31, eof31;
  logic [7:0]   d31;
  logic [0:0]   r31;
  logic [1:0]   c31;

  frame_pixel_streamer #(.WIDTH(10), .HEIGHT(10)) u10 (
    .clk(clk), .rst(rst), .frame_in(f10), .start(s10),
    .busy(busy10), .done(done10), .pix_data(d10), .pix_bin(b10),
    .pix_valid(v10), .pix_ready(ready), .pix_sof(sof10),
    .pix_eol(eol10), .pix_eof(eof10), .pix_row(r10), .pix_col(c10)
  );

  frame_pixel_streamer #(.WIDTH(1), .HEIGHT(1)) u11 (
    .clk(clk), .rst(rst), .frame_in(f11), .start(s11),
    .busy(busy11), .done(done11), .pix_data(d11), .pix_bin(b11),
    .pix_valid(v11), .pix_ready(ready), .pix_sof(sof11),
    .pix_eol(eol11), .pix_eof(eof11), .pix_row(r11), .pix_col(c11)
  );

  frame_pixel_streamer #(.WIDTH(3), .HEIGHT(1)) u31 (
    .clk(clk), .rst(rst), .frame_in(f31), .start(s31),
    .busy(busy31), .done(done31), .pix_data(d31), .pix_bin(b31),
    .pix_valid(v31), .pix_ready(ready), .pix_sof(sof31),
    .pix_eol(eol31), .pix_eof(eof31), .pix_row(r31), .pix_col(c31)
  );

  int errors = 0;
  int checks = 0;
  beat_t q10[$], q11[$], q31[$];
  int acc10 = 0, acc11 = 0, acc31 = 0;
  int dn10 = 0, dn11 = 0, dn31 = 0;

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic cmp_beat(string nm, beat_t a, beat_t e);
    checks++;
    if (a.data != e.data || a.bin != e.bin || a.row != e.row ||
        a.col != e.col || a.sof != e.sof || a.eol != e.eol ||
        a.eof != e.eof) begin
      errors++;
      $display("FAIL %s: got d=%0d b=%0d r=%0d c=%0d sof=%0d eol=%0d eof=%0d expected d=%0d b=%0d r=%0d c=%0d sof=%0d eol=%0d eof=%0d",
               nm, a.data, a.bin, a.row, a.col, a.sof, a.eol, a.eof,
               e.data, e.bin, e.row, e.col, e.sof, e.eol, e.eof);
    end
  endtask

  function automatic beat_t mk(int w, int h, int p, int v);
    beat_t b;
    b.data = v;
    b.bin  = (v != 0) ? 1 : 0;
    b.row  = p / w;
    b.col  = p % w;
    b.sof  = (p == 0) ? 1 : 0;
    b.eol  = (p % w == w - 1) ? 1 : 0;
    b.eof  = (p == w * h - 1) ? 1 : 0;
    return b;
  endfunction

  beat_t held10;
  bit    stall10 = 1'b0;

  always @(negedge clk) begin
    beat_t a, e;
    a.data = int'(d10);   a.bin = int'(b10);
    a.row  = int'(r10);   a.col = int'(c10);
    a.sof  = int'(sof10); a.eol = int'(eol10); a.eof = int'(eof10);
    if (stall10 && !rst) begin
      chk("stall_valid_held", int'(v10), 1);
      cmp_beat("stall_fields_held", a, held10);
    end
    stall10 = v10 && !ready && !rst;
    held10  = a;
    if (v10 && ready && !rst) begin
      chk("beat10_expected", int'(q10.size() > 0), 1);
      if (q10.size() > 0) begin
        e = q10.pop_front();
        cmp_beat("beat10", a, e);
      end
      acc10++;
    end
    if (done10) dn10++;
  end

  always @(negedge clk) begin
    beat_t a, e;
    if (v11 && ready && !rst) begin
      a.data = int'(d11);   a.bin = int'(b11);
      a.row  = int'(r11);   a.col = int'(c11);
      a.sof  = int'(sof11); a.eol = int'(eol11); a.eof = int'(eof11);
      chk("beat11_expected", int'(q11.size() > 0), 1);
      if (q11.size() > 0) begin
        e = q11.pop_front();
        cmp_beat("beat11", a, e);
      end
      acc11++;
    end
    if (v31 && ready && !rst) begin
      a.data = int'(d31);   a.bin = int'(b31);
      a.row  = int'(r31);   a.col = int'(c31);
      a.sof  = int'(sof31); a.eol = int'(eol31); a.eof = int'(eof31);
      chk("beat31_expected", int'(q31.size() > 0), 1);
      if (q31.size() > 0) begin
        e = q31.pop_front();
        cmp_beat("beat31", a, e);
      end
      acc31++;
    end
    if (done11) dn11++;
    if (done31) dn31++;
  end

  // mode 0: pixel p = p; 1: 0x00/0xFF checkerboard; 2: random
  task automatic run10(int mode, int rnd, int repulse_at, int rst_at);
    logic [7:0] v;
    int n, a0, d0;
    bit repulsed;
    repulsed = 1'b0;
    a0 = acc10;
    d0 = dn10;
    for (int p = 0; p < 100; p++) begin
      if (mode == 0) v = 8'(p);
      else if (mode == 1) v = (((p / 10) + (p % 10)) % 2 == 1) ? 8'hFF : 8'h00;
      else v = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
      for (int k = 0; k < 8; k++) f10[8*p+k] = v[k];
      q10.push_back(mk(10, 10, p, int'(v)));
    end
    ready = 1'b1;
    @(posedge clk); #1 s10 = 1'b1;
    @(posedge clk); #1 s10 = 1'b0;
    chk("busy_after_start", int'(busy10), 1);
    chk("valid_not_yet", int'(v10), 0);
    n = 0;
    while (n < 2000 && !done10) begin
      if (rst_at >= 0 && acc10 - a0 >= rst_at) begin
        ready = 1'b0;
        rst   = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        chk("rst_valid", int'(v10), 0);
        chk("rst_done", int'(done10), 0);
        chk("rst_busy", int'(busy10), 0);
        chk("rst_beats_seen", acc10 - a0, rst_at);
        q10.delete();
        ready = 1'b1;
        repeat (4) @(posedge clk);
        #1 chk("rst_no_done", dn10 - d0, 0);
        chk("rst_stays_idle", int'(busy10), 0);
        return;
      end
      if (repulse_at >= 0 && !repulsed && acc10 - a0 >= repulse_at) begin
        f10 = ~f10;
        s10 = 1'b1;
        repulsed = 1'b1;
      end else begin
        s10 = 1'b0;
      end
      ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk); #1;
      n++;
      if (n == 1) chk("valid_after_1", int'(v10), 1);
    end
    s10 = 1'b0;
    chk("done_seen", int'(done10), 1);
    if (!rnd) chk("done_latency", n, 101);
    chk("beats_at_done", acc10 - a0, 100);
    chk("queue_drained", q10.size(), 0);
    chk("valid_low_at_done", int'(v10), 0);
    s10 = 1'b1;
    @(posedge clk); #1 s10 = 1'b0;
    chk("done_one_cycle", int'(done10), 0);
    chk("idle_after_done", int'(busy10), 0);
    @(posedge clk); #1;
    chk("start_at_done_ignored", int'(busy10), 0);
    chk("one_done_pulse", dn10 - d0, 1);
  endtask

  task automatic run_small(int w);
    logic [7:0] v;
    int n, a0, d0;
    a0 = (w == 1) ? acc11 : acc31;
    d0 = (w == 1) ? dn11 : dn31;
    for (int p = 0; p < w; p++) begin
      v = (p == 1) ? 8'h00 : 8'($urandom_range(1, 255));
      for (int k = 0; k < 8; k++) begin
        if (w == 1) f11[8*p+k] = v[k];
        else f31[8*p+k] = v[k];
      end
      if (w == 1) q11.push_back(mk(1, 1, p, int'(v)));
      else q31.push_back(mk(3, 1, p, int'(v)));
    end
    ready = 1'b1;
    @(posedge clk); #1;
    if (w == 1) s11 = 1'b1; else s31 = 1'b1;
    @(posedge clk); #1 s11 = 1'b0; s31 = 1'b0;
    n = 0;
    while (n < 50 && !((w == 1) ? done11 : done31)) begin
      @(posedge clk); #1;
      n++;
    end
    chk($sformatf("small%0d_done_latency", w), n, w + 1);
    chk($sformatf("small%0d_beats", w), ((w == 1) ? acc11 : acc31) - a0, w);
    chk($sformatf("small%0d_queue", w), (w == 1) ? q11.size() : q31.size(), 0);
    @(posedge clk); #1;
    chk($sformatf("small%0d_one_done", w), ((w == 1) ? dn11 : dn31) - d0, 1);
  endtask

  initial begin
    rst = 1'b1;
    ready = 1'b1;
    s10 = 1'b0; s11 = 1'b0; s31 = 1'b0;
    f10 = '0; f11 = '0; f31 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", int'(busy10), 0);
    chk("reset_done", int'(done10), 0);
    chk("reset_valid", int'(v10), 0);
    chk("reset_data", int'(d10), 0);
    chk("reset_sof", int'(sof10), 0);
    chk("reset_row", int'(r10), 0);
    chk("reset_col", int'(c10), 0);
    rst = 1'b0;
    @(posedge clk); #1;
    run10(0, 0, -1, -1);
    run10(1, 0, -1, -1);
    run10(2, 1, -1, -1);
    run10(0, 0, 40, -1);
    run10(2, 1, -1, 57);
    run10(0, 0, -1, -1);
    run_small(1);
    run_small(3);
    run_small(3);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
